avalon_rr_arbiter2: RTL and testbench
=====================================

Name: avalon_rr_arbiter2

Overview:
- Two-master round-robin arbiter sharing one 32-bit Avalon-MM style slave port, e.g. the `bridge32` upstream side or a 32-bit memory.
- Typical masters: CPU data port (m0) and the loader/debug port (m1).
- Zero-latency read data, waitrequest-based handshake throughout.
- Grant is registered, so arbitration adds one cycle from idle; back-to-back handover between masters costs no idle cycle.

Parameters:
- WIDTHA, 8, address width (same on both masters and the slave).
- WIDTHD, 32, data width; byteenable width is WIDTHD/8.
- TIMEOUT, 255, watchdog limit in cycles (only used with ARB_TIMEOUT_EN); must be ≥1.

Ports:
- clock  in  1  system clock
- areset_n  in  1  asynchronous active-low reset
- m0_address  in  WIDTHA  master 0 address
- m0_byteenable  in  WIDTHD/8  master 0 byte enables
- m0_writedata  in  WIDTHD  master 0 write data
- m0_readdata  out  WIDTHD  master 0 read data
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_waitrequest  out  1  master 0 stall
- m1_address, m1_byteenable, m1_writedata, m1_readdata, m1_read, m1_write, m1_waitrequest: identical to m0_*, for master 1
- s_address  out  WIDTHA  slave address
- s_byteenable  out  WIDTHD/8  slave byte enables
- s_writedata  out  WIDTHD  slave write data
- s_readdata  in  WIDTHD  slave read data
- s_read  out  1  slave read
- s_write  out  1  slave write
- s_waitrequest  in  1  slave stall
- grant  out  2  one-hot current grant; 00 = idle
- timeout_error  out  1  sticky watchdog flag

Behaviour:
- Request definitions: req0 = m0_read|m0_write; req1 = m1_read|m1_write.
- State machine: IDLE, GNT0, GNT1. `grant` reflects the state: 00, 01, 10.
- Reset (areset_n low, asynchronous): state IDLE, last_served=1 (so m0 wins the first tie), watchdog=0, timeout_error=0.
- Combinational outputs during reset and IDLE:
  - s_read=s_write=0; s_address, s_byteenable, s_writedata all 0.
  - m0_waitrequest=m1_waitrequest=1; m*_readdata=0.
- IDLE transitions:
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both → the master != last_served.
  - Neither → stay IDLE.
  - The requester sees waitrequest=1 during the IDLE cycle.
- GNTx forwarding:
  - s_* mirror mx_* combinationally, and mx_waitrequest = s_waitrequest.
  - mx_readdata = s_readdata; the non-granted master's readdata = 0.
  - The non-granted master sees waitrequest=1.
- Completion: reqx & ~s_waitrequest in GNTx. On completion, last_served <= x and the next state is chosen as:
  - Other master requesting → GNT(other); its transfer is forwarded next cycle with no IDLE gap.
  - Otherwise, mx still requesting → stay GNTx (back-to-back).
  - Otherwise → IDLE.
- Abort: reqx drops in GNTx before completion (protocol violation) → IDLE. last_served is unchanged.
- One transfer per grant when both masters contend, giving strict alternation and no starvation.
- Reads and writes from the same master are treated identically. Read and write asserted together are forwarded as-is; the slave defines the result.
- Mid-transfer reset: outputs return to reset values immediately and the in-flight transfer is dropped.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counter increments each cycle in GNTx while s_waitrequest=1, and clears on completion, abort, or IDLE.
  - When it reaches TIMEOUT, the arbiter forces completion for that cycle: mx_waitrequest=0, mx_readdata=0xDEAD_BEEF truncated/zero-extended to WIDTHD.
  - In that same cycle it deasserts s_read/s_write, sets timeout_error (sticky until reset), and follows the normal completion transitions.
- Without the macro: no counter is built, timeout_error is tied 0, and a stalled slave stalls the granted master indefinitely.

Test Plan:
- Reset, then m0 read at addr 0x10 with slave waitrequest=0 and s_readdata=0x12345678 → grant=01 one cycle after the request; m0 sees waitrequest 1 then 0 with readdata 0x12345678; then IDLE.
- Both masters write continuously from idle (m0 data 0xAAAA0000+n, m1 data 0xBBBB0000+n) with slave always ready → grants 01,10,01,10…; no IDLE cycle between; slave sees alternating writes in order with no lost or duplicated beats.
- m1 read while slave holds waitrequest 3 cycles, m0 requests during the stall → m1 remains granted, completes on cycle 4, then grant=10 → 01 next cycle; m0 waitrequest=1 throughout the stall.
- m0 issues 4 back-to-back reads, m1 idle → grant stays 01 for all 4, one transfer per cycle after the first.
- m1 asserts read then drops it before the slave accepts → state IDLE next cycle; a following simultaneous request grants m1 again (last_served unchanged = 0 from prior m0 transfer).
- With ARB_TIMEOUT_EN and TIMEOUT=4, slave waitrequest stuck 1, m0 read → m0 waitrequest drops on the 4th stalled cycle with readdata 0xDEADBEEF; timeout_error=1 and stays 1 until areset_n is pulsed.

Source files
------------

// File: rtl/avalon_rr_arbiter2.sv
// Two-master round-robin arbiter onto one Avalon-MM slave port, with registered grant and zero-latency forwarding.
// Optional slave watchdog enabled by defining ARB_TIMEOUT_EN.
module avalon_rr_arbiter2 #(
    parameter int WIDTHA  = 8,
    parameter int WIDTHD  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  areset_n,
    input  logic [WIDTHA-1:0]     m0_address,
    input  logic [WIDTHD/8-1:0]   m0_byteenable,
    input  logic [WIDTHD-1:0]     m0_writedata,
    output logic [WIDTHD-1:0]     m0_readdata,
    input  logic                  m0_read,
    input  logic                  m0_write,
    output logic                  m0_waitrequest,
    input  logic [WIDTHA-1:0]     m1_address,
    input  logic [WIDTHD/8-1:0]   m1_byteenable,
    input  logic [WIDTHD-1:0]     m1_writedata,
    output logic [WIDTHD-1:0]     m1_readdata,
    input  logic                  m1_read,
    input  logic                  m1_write,
    output logic                  m1_waitrequest,
    output logic [WIDTHA-1:0]     s_address,
    output logic [WIDTHD/8-1:0]   s_byteenable,
    output logic [WIDTHD-1:0]     s_writedata,
    input  logic [WIDTHD-1:0]     s_readdata,
    output logic                  s_read,
    output logic                  s_write,
    input  logic                  s_waitrequest,
    output logic [1:0]            grant,
    output logic                  timeout_error
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   req0, req1, gnt_req, forced;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign grant   = state_q;
    assign gnt_req = (state_q == GNT0) ? req0 : (state_q == GNT1) ? req1 : 1'b0;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_q, wdog_d;
    logic          terr_q, terr_d;

    function automatic logic [WIDTHD-1:0] dead_beef();
        logic [WIDTHD+31:0] t;
        t = {{WIDTHD{1'b0}}, 32'hDEAD_BEEF};
        return t[WIDTHD-1:0];
    endfunction

    // The forcing cycle is the TIMEOUT-th consecutive stalled cycle of the granted transfer.
    assign forced = gnt_req && s_waitrequest && (wdog_q == TW'(TIMEOUT - 1));

    always_comb begin
        wdog_d = '0;
        if (gnt_req && s_waitrequest && !forced) begin
            wdog_d = wdog_q + 1'b1;
        end
        terr_d = terr_q | forced;
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            wdog_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_error = terr_q;
`else
    assign forced        = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        s_address      = '0;
        s_byteenable   = '0;
        s_writedata    = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (state_q)
            IDLE: begin
                // On a tie, last_q=1 means m1 was served last, so m0 goes next.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                s_read         = m0_read;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
`ifdef ARB_TIMEOUT_EN
                if (forced) begin
                    s_read         = 1'b0;
                    s_write        = 1'b0;
                    m0_waitrequest = 1'b0;
                    m0_readdata    = dead_beef();
                end
`endif
                if (!req0) begin
                    state_d = IDLE;
                end else if (!s_waitrequest || forced) begin
                    last_d  = 1'b0;
                    state_d = req1 ? GNT1 : GNT0;
                end
            end
            GNT1: begin
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                s_read         = m1_read;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
`ifdef ARB_TIMEOUT_EN
                if (forced) begin
                    s_read         = 1'b0;
                    s_write        = 1'b0;
                    m1_waitrequest = 1'b0;
                    m1_readdata    = dead_beef();
                end
`endif
                if (!req1) begin
                    state_d = IDLE;
                end else if (!s_waitrequest || forced) begin
                    last_d  = 1'b1;
                    state_d = req0 ? GNT0 : GNT1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_rr_arbiter2.sv
// Self-checking bench for avalon_rr_arbiter2: directed scenarios plus random traffic against a transaction-level model.
module tb_avalon_rr_arbiter2;
    localparam int WA = 8;
    localparam int WD = 32;
    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock, areset_n;
    logic [WA-1:0] m0_address, m1_address, s_address;
    logic [3:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic [WD-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [WD-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_read, m0_write, m0_waitrequest;
    logic          m1_read, m1_write, m1_waitrequest;
    logic          s_read, s_write, s_waitrequest;
    logic [1:0]    grant;
    logic          timeout_error;

    avalon_rr_arbiter2 #(.WIDTHA(WA), .WIDTHD(WD), .TIMEOUT(TO)) dut (
        .clock(clock), .areset_n(areset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .grant(grant), .timeout_error(timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: owner of the bus (-1 none), who was served last, stall count, sticky error.
    int owner, served, stalls;
    bit sticky;
    int n_owner, n_served, n_stalls;
    bit n_sticky;
    bit acc[2];
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; served = 1; stalls = 0; sticky = 1'b0;
    endtask

    task automatic check_now();
        logic [31:0] ad[2], be[2], wdat[2], rd[2];
        logic        rq[2], wr[2], req[2];
        logic [31:0] e_sa, e_be, e_sd, e_rd[2];
        logic        e_sr, e_sw, e_wait[2];
        logic [1:0]  e_g;
        bit          done, frc;
        int          o;
        #1;
        ad[0] = 32'(m0_address); ad[1] = 32'(m1_address);
        be[0] = 32'(m0_byteenable); be[1] = 32'(m1_byteenable);
        wdat[0] = m0_writedata; wdat[1] = m1_writedata;
        rq[0] = m0_read; rq[1] = m1_read; wr[0] = m0_write; wr[1] = m1_write;
        req[0] = rq[0] | wr[0]; req[1] = rq[1] | wr[1];
        e_sa = 0; e_be = 0; e_sd = 0; e_sr = 0; e_sw = 0;
        e_rd[0] = 0; e_rd[1] = 0; e_wait[0] = 1; e_wait[1] = 1;
        e_g = 2'b00; frc = 0; done = 0;
        n_owner = owner; n_served = served; n_stalls = 0; n_sticky = sticky;
        acc[0] = 0; acc[1] = 0;
        if (!areset_n) begin
            n_owner = -1; n_served = 1; n_sticky = 0;
        end else if (owner < 0) begin
            if (req[0] && req[1]) n_owner = 1 - served;
            else if (req[0]) n_owner = 0;
            else if (req[1]) n_owner = 1;
        end else begin
            o = owner;
            e_g = (o == 0) ? 2'b01 : 2'b10;
            e_sa = ad[o]; e_be = be[o]; e_sd = wdat[o]; e_sr = rq[o]; e_sw = wr[o];
            e_wait[o] = s_waitrequest; e_rd[o] = s_readdata;
            frc = TO_EN && req[o] && s_waitrequest && (stalls == TO - 1);
            if (frc) begin
                e_sr = 0; e_sw = 0; e_wait[o] = 0; e_rd[o] = 32'hDEADBEEF; n_sticky = 1;
            end
            done = req[o] && (!s_waitrequest || frc);
            if (!req[o]) n_owner = -1;
            else if (done) begin
                n_served = o;
                n_owner = req[1-o] ? 1 - o : o;
                acc[o] = 1;
            end else n_stalls = stalls + 1;
        end
        chk("grant", 32'(grant), 32'(e_g));
        chk("s_address", 32'(s_address), e_sa);
        chk("s_byteenable", 32'(s_byteenable), e_be);
        chk("s_writedata", s_writedata, e_sd);
        chk("s_read", 32'(s_read), 32'(e_sr));
        chk("s_write", 32'(s_write), 32'(e_sw));
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(e_wait[0]));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(e_wait[1]));
        chk("m0_readdata", m0_readdata, e_rd[0]);
        chk("m1_readdata", m1_readdata, e_rd[1]);
        chk("timeout_error", 32'(timeout_error), areset_n ? 32'(sticky) : 32'd0);
        if (s_write && !s_waitrequest && areset_n) wq.push_back(s_writedata);
    endtask

    task automatic advance();
        @(posedge clock);
        owner = n_owner; served = n_served; stalls = n_stalls; sticky = n_sticky;
        #1;
    endtask

    task automatic cycle();
        check_now();
        advance();
    endtask

    task automatic pulse_reset();
        areset_n = 1'b0;
        cycle();
        areset_n = 1'b1;
    endtask

    initial begin
        int n0, n1, cnt;
        logic [31:0] exp_w;
        areset_n = 1'b0;
        m0_address = '0; m0_byteenable = '0; m0_writedata = '0; m0_read = 0; m0_write = 0;
        m1_address = '0; m1_byteenable = '0; m1_writedata = '0; m1_read = 0; m1_write = 0;
        s_readdata = '0; s_waitrequest = 1'b0;
        model_reset();
        #2;
        cycle();
        cycle();
        areset_n = 1'b1;
        cycle();

        // Single m0 read
        m0_read = 1; m0_address = 8'h10; m0_byteenable = 4'hF; s_readdata = 32'h12345678;
        check_now();
        chk("t1_wait_idle", 32'(m0_waitrequest), 32'd1);
        advance();
        check_now();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_wait", 32'(m0_waitrequest), 32'd0);
        chk("t1_rdata", m0_readdata, 32'h12345678);
        advance();
        m0_read = 0;
        cycle();
        check_now();
        chk("t1_idle", 32'(grant), 32'd0);
        advance();

        // Both masters write continuously
        pulse_reset();
        n0 = 0; n1 = 0; wq.delete();
        m0_write = 1; m1_write = 1; s_waitrequest = 0;
        for (int i = 0; i < 12; i++) begin
            m0_writedata = 32'hAAAA0000 + n0;
            m1_writedata = 32'hBBBB0000 + n1;
            check_now();
            advance();
            if (acc[0]) n0++;
            if (acc[1]) n1++;
        end
        m0_write = 0; m1_write = 0;
        cycle();
        cycle();
        chk("t2_beats", wq.size(), 32'd11);
        for (int i = 0; i < wq.size(); i++) begin
            exp_w = (i % 2 == 0) ? 32'hAAAA0000 + 32'(i / 2) : 32'hBBBB0000 + 32'(i / 2);
            chk("t2_order", wq[i], exp_w);
        end

        // m1 read stalled 3 cycles while m0 waits
        m1_read = 1; m1_address = 8'h22; s_waitrequest = 1; s_readdata = 32'hCAFE0001;
        cycle();
        m0_read = 1; m0_address = 8'h33;
        for (int k = 0; k < 3; k++) begin
            check_now();
            chk("t3_grant_stall", 32'(grant), 32'd2);
            chk("t3_m0_wait", 32'(m0_waitrequest), 32'd1);
            advance();
        end
        s_waitrequest = 0;
        check_now();
        chk("t3_m1_done", 32'(m1_waitrequest), 32'd0);
        advance();
        m1_read = 0;
        check_now();
        chk("t3_handover", 32'(grant), 32'd1);
        advance();
        m0_read = 0;
        cycle();
        cycle();

        // m0 back-to-back reads
        m0_read = 1; cnt = 0;
        for (int i = 0; i < 10 && cnt < 4; i++) begin
            s_readdata = 32'h5000 + 32'(cnt);
            check_now();
            if (acc[0]) begin
                chk("t4_grant", 32'(grant), 32'd1);
                chk("t4_rdata", m0_readdata, 32'h5000 + 32'(cnt));
                cnt++;
            end
            advance();
        end
        chk("t4_count", 32'(cnt), 32'd4);
        m0_read = 0;
        cycle();
        cycle();

        // m1 aborts; next tie still goes to m1
        m1_read = 1; s_waitrequest = 1;
        cycle();
        cycle();
        m1_read = 0;
        cycle();
        check_now();
        chk("t5_idle", 32'(grant), 32'd0);
        advance();
        m0_read = 1; m1_read = 1; s_waitrequest = 0;
        cycle();
        check_now();
        chk("t5_tie_m1", 32'(grant), 32'd2);
        advance();
        m0_read = 0; m1_read = 0;
        cycle();
        cycle();

        // Mid-transfer reset drops the transfer at once
        m0_write = 1; s_waitrequest = 1;
        cycle();
        cycle();
        areset_n = 0;
        check_now();
        chk("mid_reset_grant", 32'(grant), 32'd0);
        chk("mid_reset_swrite", 32'(s_write), 32'd0);
        advance();
        areset_n = 1; m0_write = 0; s_waitrequest = 0;
        cycle();

`ifdef ARB_TIMEOUT_EN
        // Watchdog forces completion on the 4th stalled cycle
        m0_read = 1; s_waitrequest = 1; s_readdata = 32'h0;
        cycle();
        for (int k = 1; k <= 4; k++) begin
            check_now();
            if (k == 4) begin
                chk("to_wait", 32'(m0_waitrequest), 32'd0);
                chk("to_rdata", m0_readdata, 32'hDEADBEEF);
                chk("to_sread", 32'(s_read), 32'd0);
            end else begin
                chk("to_stall", 32'(m0_waitrequest), 32'd1);
            end
            advance();
        end
        m0_read = 0;
        check_now();
        chk("to_sticky", 32'(timeout_error), 32'd1);
        advance();
        cycle();
        cycle();
        chk("to_sticky_hold", 32'(timeout_error), 32'd1);
        pulse_reset();
        chk("to_cleared", 32'(timeout_error), 32'd0);
        s_waitrequest = 0;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            m0_read = ($urandom_range(0, 3) == 0); m0_write = ($urandom_range(0, 4) == 0);
            m1_read = ($urandom_range(0, 3) == 0); m1_write = ($urandom_range(0, 4) == 0);
            m0_address = WA'($urandom); m1_address = WA'($urandom);
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            m0_writedata = $urandom; m1_writedata = $urandom;
            s_readdata = $urandom;
            s_waitrequest = ($urandom_range(0, 9) < 4);
            areset_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        areset_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
